// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding and output buffer sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_rd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN
  } rd_state_t;

  localparam int BUF_DEPTH = 2;

  // True while the output buffer can take another word this cycle.
  function automatic logic buf_has_room(input logic [1:0] cnt);
    return int'(cnt) < BUF_DEPTH;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry in-order buffer between the FIFO pop side and the downstream stream.
// Latency: a word pushed at edge N is on head_dat after edge N when the buffer was empty.
// Backpressure: caller must not push when full; pop is ignored when empty.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic                  head_vld,
  output logic [1:0]            cnt
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  logic [1:0]            cnt_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign push_ok  = push & buf_has_room(cnt_q);
  assign pop_ok   = pop & (cnt_q != 2'd0);
  assign head_dat = ent0;
  assign head_vld = (cnt_q != 2'd0);
  assign cnt      = cnt_q;

  // Entry 0 is always the head; entry 1 shifts down on a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      cnt_q <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) ent0 <= push_dat;
          else               ent1 <= push_dat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            ent0 <= push_dat;
          end else begin
            ent0 <= ent1;
            ent1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-domain burst consumer: pops a programmed word count from a show-ahead FIFO into a 2-entry output buffer.
// Latency: word popped at edge N is on out_data after edge N; done pulses one cycle after the buffer empties in DRAIN.
// Backpressure: pops stop when the buffer holds 2 words; rinc has no path from out_ready. Optional checker: FIFO_RD_SEQ_CHECK_EN.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  abort,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  word_cnt,
  output logic                  seq_err
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  rd_state_t            state;
  logic [LEN_WIDTH-1:0] remain;
  logic [1:0]           buf_cnt;
  logic                 out_pop;
  logic                 last_pop;

  assign rinc = (state == READ) & ~rempty & (remain != '0) & buf_has_room(buf_cnt) & ~abort;
  assign busy     = (state != IDLE);
  assign out_pop  = out_valid & out_ready;
  assign last_pop = rinc & (remain == LEN_ONE);

  fifo_rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (rclk),
    .rst      (rrst),
    .push     (rinc),
    .push_dat (rdata),
    .pop      (out_pop),
    .head_dat (out_data),
    .head_vld (out_valid),
    .cnt      (buf_cnt)
  );

  // Burst sequencing: latch length on start, count pops, drain the buffer, then pulse done.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state    <= IDLE;
      remain   <= '0;
      word_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            remain   <= burst_len;
            word_cnt <= '0;
          end
        end
        READ: begin
          if (rinc) begin
            remain   <= remain - LEN_ONE;
            word_cnt <= word_cnt + LEN_ONE;
          end
          // rinc is already low under abort, so abort wins over a final pop.
          if (abort || (remain == '0) || last_pop) state <= DRAIN;
        end
        DRAIN: begin
          if (buf_cnt == 2'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_SEQ_CHECK_EN
  logic [DATA_WIDTH-1:0] seq_expect;
  logic                  seq_first;
  logic                  seq_err_q;

  // Each pop after the first of a burst must carry the previous word plus one.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      seq_expect <= '0;
      seq_first  <= 1'b1;
      seq_err_q  <= 1'b0;
    end else if ((state == IDLE) && start) begin
      seq_first <= 1'b1;
      seq_err_q <= 1'b0;
    end else if (rinc) begin
      if (!seq_first && (rdata != seq_expect)) seq_err_q <= 1'b1;
      seq_expect <= rdata + 1'b1;
      seq_first  <= 1'b0;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int LW = 4;
`ifdef FIFO_RD_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rrst;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          abort;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [LW-1:0] word_cnt;
  logic          seq_err;

  // FIFO model
  logic [DW-1:0] mem [0:31];
  logic [5:0]    rd_ptr = '0;
  logic [5:0]    wr_ptr;
  logic          flush = 1'b0;

  // Monitor state
  logic          clr_mon = 1'b0;
  int            cyc = 0;
  int            rx_n = 0;
  int            done_cnt = 0;
  int            rinc_cnt = 0;
  int            run = 0;
  int            max_run = 0;
  int            last_acc_cyc = 0;
  int            done_cyc = 0;
  logic [DW-1:0] rx [0:31];

  int errors = 0;
  int checks = 0;

  always #5 rclk = ~rclk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .start     (start),
    .burst_len (burst_len),
    .abort     (abort),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt),
    .seq_err   (seq_err)
  );

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr[4:0]];

  always @(posedge rclk) begin
    if (flush)     rd_ptr <= wr_ptr;
    else if (rinc) rd_ptr <= rd_ptr + 6'd1;
  end

  always @(negedge rclk) begin
    cyc = cyc + 1;
    if (clr_mon) begin
      rx_n = 0; done_cnt = 0; rinc_cnt = 0; run = 0; max_run = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (rx_n < 32) rx[rx_n] = out_data;
        rx_n = rx_n + 1;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (rinc) begin
        rinc_cnt = rinc_cnt + 1;
        run = run + 1;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(negedge rclk);
    #1;
    clr_mon = 1'b0;
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    @(posedge rclk);
    #1;
    flush = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] v);
    mem[wr_ptr[4:0]] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic fill_seq(input int first, input int n);
    for (int i = 0; i < n; i++) fill(DW'(first + i));
  endtask

  task automatic do_start(input logic [LW-1:0] len);
    start = 1'b1;
    burst_len = len;
    @(posedge rclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
    tick(2);
  endtask

  task automatic test_reset();
    rrst = 1'b1; start = 1'b0; burst_len = '0; abort = 1'b0; out_ready = 1'b0;
    tick(2);
    checks++; if (rinc !== 1'b0)      begin errors++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (word_cnt !== 4'd0)  begin errors++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    checks++; if (seq_err !== 1'b0)   begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    rrst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    clear_mon();
    fill_seq(1, 8);
    out_ready = 1'b1;
    do_start(4'd8);
    wait_done(60);
    checks++; if (rinc_cnt != 8) begin errors++; $display("FAIL basic_pops: got %0d want 8", rinc_cnt); end
    checks++; if (max_run != 8)  begin errors++; $display("FAIL basic_rinc_run: got %0d want 8", max_run); end
    checks++; if (rx_n != 8)     begin errors++; $display("FAIL basic_rx_count: got %0d want 8", rx_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx[i] !== DW'(i + 1)) begin errors++; $display("FAIL basic_rx[%0d]: got %0d want %0d", i, rx[i], i + 1); end
    end
    checks++; if (done_cnt != 1)     begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (word_cnt !== 4'd8) begin errors++; $display("FAIL basic_word_cnt: got %0d want 8", word_cnt); end
    checks++; if (seq_err !== 1'b0)  begin errors++; $display("FAIL basic_seq_err: got %b want 0", seq_err); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    fill_seq(1, 8);
    out_ready = 1'b0;
    do_start(4'd8);
    tick(8);
    checks++; if (rinc_cnt != 2)      begin errors++; $display("FAIL bp_pops: got %0d want 2", rinc_cnt); end
    checks++; if (rinc !== 1'b0)      begin errors++; $display("FAIL bp_rinc: got %b want 0", rinc); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'd1)  begin errors++; $display("FAIL bp_out_data: got %0d want 1", out_data); end
    checks++; if (word_cnt !== 4'd2)  begin errors++; $display("FAIL bp_word_cnt: got %0d want 2", word_cnt); end
    out_ready = 1'b1;
    wait_done(60);
    checks++; if (rx_n != 8) begin errors++; $display("FAIL bp_rx_count: got %0d want 8", rx_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx[i] !== DW'(i + 1)) begin errors++; $display("FAIL bp_rx[%0d]: got %0d want %0d", i, rx[i], i + 1); end
    end
    checks++; if (done_cnt != 1)     begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    checks++; if (word_cnt !== 4'd8) begin errors++; $display("FAIL bp_word_cnt_end: got %0d want 8", word_cnt); end
  endtask

  task automatic test_empty_wait();
    logic [DW-1:0] exp_w [0:2];
    exp_w[0] = 8'hA1; exp_w[1] = 8'hB2; exp_w[2] = 8'hC3;
    clear_mon();
    out_ready = 1'b1;
    do_start(4'd3);
    tick(5);
    checks++; if (rinc_cnt != 0)      begin errors++; $display("FAIL empty_pops: got %0d want 0", rinc_cnt); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL empty_busy: got %b want 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_out_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) fill(exp_w[i]);
    wait_done(40);
    checks++; if (rx_n != 3) begin errors++; $display("FAIL empty_rx_count: got %0d want 3", rx_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx[i] !== exp_w[i]) begin errors++; $display("FAIL empty_rx[%0d]: got %h want %h", i, rx[i], exp_w[i]); end
    end
    checks++; if (done_cyc <= last_acc_cyc) begin errors++; $display("FAIL empty_done_order: done cycle %0d, last accept cycle %0d", done_cyc, last_acc_cyc); end
    checks++; if (word_cnt !== 4'd3) begin errors++; $display("FAIL empty_word_cnt: got %0d want 3", word_cnt); end
  endtask

  task automatic test_abort();
    clear_mon();
    fill_seq(1, 8);
    out_ready = 1'b1;
    do_start(4'd8);
    for (int n = 0; n < 20; n++) begin
      if (rinc_cnt >= 3) break;
      tick(1);
    end
    abort = 1'b1;
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL abort_rinc: got %b want 0", rinc); end
    tick(1);
    abort = 1'b0;
    wait_done(40);
    checks++; if (rinc_cnt != 3) begin errors++; $display("FAIL abort_pops: got %0d want 3", rinc_cnt); end
    checks++; if (rx_n != 3)     begin errors++; $display("FAIL abort_rx_count: got %0d want 3", rx_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx[i] !== DW'(i + 1)) begin errors++; $display("FAIL abort_rx[%0d]: got %0d want %0d", i, rx[i], i + 1); end
    end
    checks++; if (done_cnt != 1)     begin errors++; $display("FAIL abort_done_count: got %0d want 1", done_cnt); end
    checks++; if (word_cnt !== 4'd3) begin errors++; $display("FAIL abort_word_cnt: got %0d want 3", word_cnt); end
    flush_fifo();
  endtask

  task automatic test_zero_len();
    clear_mon();
    fill(8'h99);
    do_start(4'd0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_c1: got %b want 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_c1: got %b want 1", busy); end
    tick(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_c2: got %b want 0", done); end
    tick(1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_c3: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_c3: got %b want 0", busy); end
    tick(1);
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL zero_done_c4: got %b want 0", done); end
    checks++; if (rinc_cnt != 0)     begin errors++; $display("FAIL zero_pops: got %0d want 0", rinc_cnt); end
    checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL zero_word_cnt: got %0d want 0", word_cnt); end
    flush_fifo();
  endtask

  task automatic test_reset_mid_burst();
    clear_mon();
    fill_seq(1, 8);
    out_ready = 1'b0;
    do_start(4'd8);
    tick(4);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    checks++; if (word_cnt !== 4'd2)  begin errors++; $display("FAIL mid_pre_word_cnt: got %0d want 2", word_cnt); end
    rrst = 1'b1;
    tick(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (word_cnt !== 4'd0)  begin errors++; $display("FAIL mid_word_cnt: got %0d want 0", word_cnt); end
    checks++; if (rinc !== 1'b0)      begin errors++; $display("FAIL mid_rinc: got %b want 0", rinc); end
    rrst = 1'b0;
    tick(4);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL mid_done_count: got %0d want 0", done_cnt); end
    flush_fifo();
  endtask

  task automatic test_seq_check();
    clear_mon();
    out_ready = 1'b1;
    fill(8'd1); fill(8'd2); fill(8'd4); fill(8'd5);
    do_start(4'd4);
    tick(2);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_before: got %b want 0", seq_err); end
    tick(1);
    checks++; if (seq_err !== SEQ_EN) begin errors++; $display("FAIL seq_rise: got %b want %b", seq_err, SEQ_EN); end
    wait_done(40);
    checks++; if (seq_err !== SEQ_EN) begin errors++; $display("FAIL seq_sticky: got %b want %b", seq_err, SEQ_EN); end
    clear_mon();
    fill(8'd6); fill(8'd7);
    do_start(4'd2);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_clear_on_start: got %b want 0", seq_err); end
    wait_done(40);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_clean_burst: got %b want 0", seq_err); end
    checks++; if (rx_n != 2)        begin errors++; $display("FAIL seq_rx_count: got %0d want 2", rx_n); end
  endtask

  initial begin
    wr_ptr = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_wait();
    test_abort();
    test_zero_len();
    test_reset_mid_burst();
    test_seq_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
